// File: rtl/ncl_seq_pkg.sv
// Shared types and dual-rail helpers for the clocked NCL multiplier.
// Rail vectors are handled at a fixed maximum width; callers pass the live width.
package ncl_seq_pkg;

    localparam int MAX_W = 32;

    typedef logic [MAX_W-1:0] rail_t;

    typedef enum logic [2:0] {
        WAIT_DATA,
        MULT,
        DRIVE,
        HOLD,
        RETURN
    } state_t;

    function automatic logic dr_all_data(
        input rail_t r1,
        input rail_t r0,
        input int    n
    );
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < n && (r1[i] == r0[i])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic logic dr_all_null(
        input rail_t r1,
        input rail_t r0
    );
        return ((r1 | r0) == '0);
    endfunction

    function automatic logic dr_illegal(
        input rail_t r1,
        input rail_t r0
    );
        return |(r1 & r0);
    endfunction

    // Returns {rail1, rail0}; bits at or above n stay NULL.
    function automatic logic [2*MAX_W-1:0] dr_encode(
        input rail_t value,
        input int    n
    );
        rail_t mask;
        mask = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < n) begin
                mask[i] = 1'b1;
            end
        end
        return {value & mask, ~value & mask};
    endfunction

endpackage

// File: rtl/ncl_dr_sync.sv
// Multi-flop synchroniser over a dual-rail bundle plus a two-sample
// stability filter and completion detection on the synchronised rails.
module ncl_dr_sync #(
    parameter int N      = 6,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] rail1,
    input  logic [N-1:0] rail0,
    output logic [N-1:0] sync_rail1,
    output logic [N-1:0] sync_rail0,
    output logic         stable_data,
    output logic         stable_null,
    output logic         illegal
);
    import ncl_seq_pkg::*;

    logic [2*N-1:0] pipe [STAGES];
    logic [2*N-1:0] cur;
    logic [2*N-1:0] prev;
    logic           same;

    // Synchroniser chain; prev keeps the previous synchronised sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe[k] <= '0;
            end
            prev <= '0;
        end else begin
            pipe[0] <= {rail1, rail0};
            for (int k = 1; k < STAGES; k++) begin
                pipe[k] <= pipe[k-1];
            end
            prev <= pipe[STAGES-1];
        end
    end

    assign cur        = pipe[STAGES-1];
    assign sync_rail1 = cur[2*N-1:N];
    assign sync_rail0 = cur[N-1:0];
    assign same       = (cur == prev);

    assign stable_data = same &&
        dr_all_data(rail_t'(sync_rail1), rail_t'(sync_rail0), N);
    assign stable_null = same &&
        dr_all_null(rail_t'(sync_rail1), rail_t'(sync_rail0));
    assign illegal =
        dr_illegal(rail_t'(sync_rail1), rail_t'(sync_rail0));

endmodule

// File: rtl/ncl_mult_seq.sv
// Clocked dual-rail shift-add multiplier bridging an NCL four-phase
// handshake into the clock domain, unsigned or two's-complement.
module ncl_mult_seq #(
    parameter int WIDTH       = 3,
    parameter int SIGNED      = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a_rail1,
    input  logic [WIDTH-1:0]     a_rail0,
    input  logic [WIDTH-1:0]     b_rail1,
    input  logic [WIDTH-1:0]     b_rail0,
    input  logic                 ki,
    output logic                 ko,
    output logic [2*WIDTH-1:0]   p_rail1,
    output logic [2*WIDTH-1:0]   p_rail0,
    output logic                 busy,
    output logic                 err
);
    import ncl_seq_pkg::*;

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    s_rail1;
    logic [PW-1:0]    s_rail0;
    logic             stable_data;
    logic             stable_null;
    logic             illegal;

    logic [SYNC_STAGES-1:0] ki_pipe;
    logic             ki_s;

    state_t           state;
    state_t           state_nxt;
    logic [4:0]       cnt;
    logic             mult_last;

    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_val;
    logic             sgn_a;
    logic             sgn_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic             neg;
    logic [PW-1:0]    prod_out;
    logic [PW-1:0]    p1_d;
    logic [PW-1:0]    p0_d;

    logic [PW-1:0]    p1_q;
    logic [PW-1:0]    p0_q;
    logic             ko_q;
    logic             busy_q;
    logic             err_q;

    ncl_dr_sync #(
        .N      (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .rail1       ({a_rail1, b_rail1}),
        .rail0       ({a_rail0, b_rail0}),
        .sync_rail1  (s_rail1),
        .sync_rail0  (s_rail0),
        .stable_data (stable_data),
        .stable_null (stable_null),
        .illegal     (illegal)
    );

    // Downstream request synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ki_pipe <= '0;
        end else begin
            ki_pipe <= {ki_pipe[SYNC_STAGES-2:0], ki};
        end
    end

    assign ki_s = ki_pipe[SYNC_STAGES-1];

    // Operand values and sign-magnitude split of the synchronised data.
    assign a_val = s_rail1[PW-1:WIDTH] & ~s_rail0[PW-1:WIDTH];
    assign b_val = s_rail1[WIDTH-1:0] & ~s_rail0[WIDTH-1:0];
    assign sgn_a = (SIGNED != 0) && a_val[WIDTH-1];
    assign sgn_b = (SIGNED != 0) && b_val[WIDTH-1];
    assign mag_a = sgn_a ? ((~a_val) + WIDTH'(1)) : a_val;
    assign mag_b = sgn_b ? ((~b_val) + WIDTH'(1)) : b_val;

    assign mult_last = (cnt == 5'(WIDTH - 1));

    // Negating zero yields zero, so a zero product is always +0.
    assign prod_out = neg ? ((~acc) + PW'(1)) : acc;
    assign p1_d = PW'(dr_encode(rail_t'(prod_out), PW) >> MAX_W);
    assign p0_d = PW'(dr_encode(rail_t'(prod_out), PW));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_DATA;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_DATA: if (stable_data) state_nxt = MULT;
            MULT:      if (mult_last) state_nxt = DRIVE;
            DRIVE:     if (cnt == 5'd0 && ki_s) state_nxt = HOLD;
            HOLD:      if (!ki_s) state_nxt = RETURN;
            RETURN:    if (stable_null) state_nxt = WAIT_DATA;
            default:   state_nxt = WAIT_DATA;
        endcase
    end

    // Datapath and registered outputs; DRIVE first waits SYNC_STAGES
    // cycles so the ki it acts on was sampled after ko fell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            p1_q   <= '0;
            p0_q   <= '0;
            ko_q   <= 1'b1;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (illegal) begin
                err_q <= 1'b1;
            end
            unique case (state)
                WAIT_DATA: begin
                    if (stable_data) begin
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        acc    <= '0;
                        neg    <= sgn_a ^ sgn_b;
                        cnt    <= '0;
                        ko_q   <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                MULT: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= mult_last ? 5'(SYNC_STAGES) : cnt + 5'd1;
                end
                DRIVE: begin
                    if (cnt != 5'd0) begin
                        cnt <= cnt - 5'd1;
                    end else if (ki_s) begin
                        p1_q <= p1_d;
                        p0_q <= p0_d;
                    end
                end
                HOLD: begin
                    if (!ki_s) begin
                        p1_q <= '0;
                        p0_q <= '0;
                    end
                end
                RETURN: begin
                    if (stable_null) begin
                        ko_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output drive from the registered state.
    always_comb begin
        ko      = ko_q;
        busy    = busy_q;
        err     = err_q;
        p_rail1 = p1_q;
        p_rail0 = p0_q;
    end

endmodule

// File: tb/tb_ncl_mult_seq.sv
// Directed bench for ncl_mult_seq: a 3-bit unsigned and a 4-bit signed
// instance driven through the four-phase handshake.
module tb_ncl_mult_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic [2:0] a1_0, a0_0, b1_0, b0_0;
    logic       ki_0, ko_0, busy_0, err_0;
    logic [5:0] p1_0, p0_0;

    logic [3:0] a1_1, a0_1, b1_1, b0_1;
    logic       ki_1, ko_1, busy_1, err_1;
    logic [7:0] p1_1, p0_1;

    ncl_mult_seq #(.WIDTH(3), .SIGNED(0), .SYNC_STAGES(2)) u_u3 (
        .clk(clk), .rst_n(rst_n),
        .a_rail1(a1_0), .a_rail0(a0_0),
        .b_rail1(b1_0), .b_rail0(b0_0),
        .ki(ki_0), .ko(ko_0),
        .p_rail1(p1_0), .p_rail0(p0_0),
        .busy(busy_0), .err(err_0)
    );

    ncl_mult_seq #(.WIDTH(4), .SIGNED(1), .SYNC_STAGES(2)) u_s4 (
        .clk(clk), .rst_n(rst_n),
        .a_rail1(a1_1), .a_rail0(a0_1),
        .b_rail1(b1_1), .b_rail0(b0_1),
        .ki(ki_1), .ko(ko_1),
        .p_rail1(p1_1), .p_rail0(p0_1),
        .busy(busy_1), .err(err_1)
    );

    int         dsel;
    logic [7:0] o_p1, o_p0, mask;
    logic       o_ko, o_busy, o_err;

    always_comb begin
        if (dsel == 0) begin
            o_p1   = {2'b00, p1_0};
            o_p0   = {2'b00, p0_0};
            mask   = 8'h3F;
            o_ko   = ko_0;
            o_busy = busy_0;
            o_err  = err_0;
        end else begin
            o_p1   = p1_1;
            o_p0   = p0_1;
            mask   = 8'hFF;
            o_ko   = ko_1;
            o_busy = busy_1;
            o_err  = err_1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_data();
        return ((o_p1 ^ o_p0) == mask) && ((o_p1 & o_p0) == 8'h00);
    endfunction

    function automatic bit is_null();
        return (o_p1 == 8'h00) && (o_p0 == 8'h00);
    endfunction

    task automatic drive_raw(input logic [7:0] a1, input logic [7:0] a0,
                             input logic [7:0] b1, input logic [7:0] b0);
        if (dsel == 0) begin
            a1_0 = a1[2:0]; a0_0 = a0[2:0];
            b1_0 = b1[2:0]; b0_0 = b0[2:0];
        end else begin
            a1_1 = a1[3:0]; a0_1 = a0[3:0];
            b1_1 = b1[3:0]; b0_1 = b0[3:0];
        end
    endtask

    task automatic drive_data(input logic [7:0] a, input logic [7:0] b);
        drive_raw(a, ~a, b, ~b);
    endtask

    task automatic drive_null();
        drive_raw(8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic set_ki(input logic v);
        if (dsel == 0) ki_0 = v;
        else ki_1 = v;
    endtask

    // Data already applied; follow the handshake to completion.
    task automatic finish_txn(input string tag, input logic [7:0] expv,
                              input int exp_lat);
        bit seen;
        int lat;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!o_ko) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " ko_fall"}, 32'(seen), 32'd1);
        if (!seen) return;
        check({tag, " busy_cap"}, 32'(o_busy), 32'd1);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (is_data()) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " p_rail1"}, 32'(o_p1), 32'(expv & mask));
        check({tag, " p_rail0"}, 32'(o_p0), 32'(~expv & mask));
        set_ki(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_null()) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " p_null"}, 32'(seen), 32'd1);
        drive_null();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_ko) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " ko_rise"}, 32'(seen), 32'd1);
        check({tag, " busy_end"}, 32'(o_busy), 32'd0);
        set_ki(1'b1);
    endtask

    typedef struct {
        int         d;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit dropped;
        bit bad;
        int lat;

        vecs[0] = '{0, 8'd5, 8'd7, 8'd35,  6};
        vecs[1] = '{0, 8'd7, 8'd7, 8'd49,  6};
        vecs[2] = '{0, 8'd0, 8'd6, 8'd0,   6};
        vecs[3] = '{0, 8'd7, 8'd0, 8'd0,   6};
        vecs[4] = '{1, 8'h8, 8'h3, 8'hE8,  7};
        vecs[5] = '{1, 8'h8, 8'h8, 8'h40,  7};
        vecs[6] = '{1, 8'h0, 8'hD, 8'h00,  7};
        vecs[7] = '{1, 8'hF, 8'h7, 8'hF9,  7};
        vecs[8] = '{1, 8'h5, 8'h6, 8'h1E,  7};

        rst_n = 1'b0;
        dsel = 0;
        drive_null();
        set_ki(1'b1);
        dsel = 1;
        drive_null();
        set_ki(1'b1);
        repeat (3) @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            dsel = d;
            #1;
            check("rst ko", 32'(o_ko), 32'd1);
            check("rst busy", 32'(o_busy), 32'd0);
            check("rst err", 32'(o_err), 32'd0);
            check("rst p_rail1", 32'(o_p1), 32'd0);
            check("rst p_rail0", 32'(o_p0), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            dsel = vecs[i].d;
            drive_data(vecs[i].a, vecs[i].b);
            finish_txn($sformatf("vec%0d", i), vecs[i].p, vecs[i].lat);
        end

        // Illegal encoding on A bit0 while waiting for data.
        dsel = 0;
        drive_raw(8'h01, 8'h07, 8'h02, 8'h05);
        dropped = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!o_ko || o_busy) dropped = 1'b1;
        end
        check("illegal err", 32'(o_err), 32'd1);
        check("illegal no_capture", 32'(dropped), 32'd0);
        drive_data(8'd3, 8'd2);
        finish_txn("after_illegal", 8'd6, 6);
        check("err sticky", 32'(o_err), 32'd1);
        dsel = 1;
        #1;
        check("err other inst", 32'(o_err), 32'd0);

        // A changes 3 -> 6 inside the stability window.
        dsel = 0;
        drive_data(8'd3, 8'd2);
        @(negedge clk);
        drive_data(8'd6, 8'd2);
        finish_txn("restab", 8'd12, 6);

        // Partial DATA: B bit2 has neither rail.
        drive_raw(8'h05, 8'h02, 8'h00, 8'h03);
        dropped = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!o_ko || o_busy) dropped = 1'b1;
        end
        check("partial no_capture", 32'(dropped), 32'd0);
        drive_data(8'd5, 8'd0);
        finish_txn("after_partial", 8'd0, 6);

        // ki low through MULT, late ki, then reset during HOLD.
        dsel = 1;
        set_ki(1'b0);
        repeat (4) @(negedge clk);
        drive_data(8'hE, 8'h5);
        dropped = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!o_ko) begin
                dropped = 1'b0;
                break;
            end
        end
        check("kilow ko_fall", 32'(!dropped), 32'd1);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!is_null()) bad = 1'b1;
        end
        check("kilow p_stays_null", 32'(bad), 32'd0);
        set_ki(1'b1);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (is_data()) begin
                lat = i;
                break;
            end
        end
        check("late_ki latency", 32'(lat), 32'd3);
        check("late_ki p_rail1", 32'(o_p1), 32'hF6);
        check("late_ki p_rail0", 32'(o_p0), 32'h09);
        #2;
        rst_n = 1'b0;
        #1;
        check("hold_rst p_rail1", 32'(o_p1), 32'd0);
        check("hold_rst p_rail0", 32'(o_p0), 32'd0);
        check("hold_rst ko", 32'(o_ko), 32'd1);
        check("hold_rst busy", 32'(o_busy), 32'd0);
        dsel = 0;
        #1;
        check("hold_rst err cleared", 32'(o_err), 32'd0);
        @(negedge clk);
        dsel = 1;
        drive_null();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ncl_mult_seq.md
Name: ncl_mult_seq

Overview:
Clocked, parametrised dual-rail (NCL-encoded) multiplier and the next generation of the 3x3 NCL array multiplier. It accepts dual-rail operands from an NCL (clockless) domain and synchronises them into the clock domain. It multiplies WIDTH x WIDTH operands over multiple cycles using shift-add, in unsigned or two's-complement mode. It returns a 2*WIDTH dual-rail product under the standard DATA/NULL four-phase Ki/Ko handshake, and sits at the boundary between the asynchronous datapath and the synchronous control fabric.

Parameters:
WIDTH, 3, operand width in bits (legal 2..16); product width is 2*WIDTH
SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands and product
SYNC_STAGES, 2, flop stages on every input rail and on ki (legal 2..3)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
a_rail1  input  WIDTH  operand A, rail1 per bit
a_rail0  input  WIDTH  operand A, rail0 per bit
b_rail1  input  WIDTH  operand B, rail1 per bit
b_rail0  input  WIDTH  operand B, rail0 per bit
ki  input  1  downstream handshake: 1 = request-for-data, 0 = request-for-null
ko  output  1  upstream handshake: 1 = request-for-data, 0 = request-for-null
p_rail1  output  2*WIDTH  product, rail1 per bit
p_rail0  output  2*WIDTH  product, rail0 per bit
busy  output  1  high from operand capture until return to WAIT_DATA
err  output  1  sticky illegal-encoding flag

Behaviour:
- Reset: clk domain only; reset is asynchronous and active-low. While rst_n=0, all outputs are registered and forced to: p_rail1=0, p_rail0=0 (NULL), ko=1, busy=0, err=0. All synchroniser flops are cleared, state=WAIT_DATA. A reset asserted mid-operation (any state) has the same effect immediately.
- Completion detection runs on the synchronised rails, per operand pair (A and B jointly):
  - all_data: every bit has exactly one rail high.
  - all_null: every rail is 0.
  - illegal: any bit has both rails high.
  - Any other pattern is partial and is treated as "wait".
- Stability: all_data must hold for 2 consecutive cycles with identical rail values. A value change inside that window restarts it. The same 2-cycle rule applies to all_null.
- FSM:
  - WAIT_DATA: ko=1. When stable all_data is seen: capture operands, set ko<=0 and busy<=1, go to MULT. If illegal is seen: err<=1, no capture.
  - MULT: WIDTH cycles, one partial-product add per cycle, cycle counter runs 0..WIDTH-1. Then go to DRIVE. ki is ignored in this state.
  - DRIVE: outputs stay NULL. When synchronised ki=1: p_rail1<=prod, p_rail0<=~prod, go to HOLD.
  - HOLD: DATA outputs are held. When synchronised ki=0: outputs go to NULL, go to RETURN.
  - RETURN: when stable all_null is seen on the inputs: ko<=1, busy<=0, go to WAIT_DATA. Upstream may reach NULL earlier; it is only checked here.
- Latency: the capture edge is E. With ki already 1, p DATA is visible at E+WIDTH+1+SYNC_STAGES. The minimum pin-to-capture delay is SYNC_STAGES+1 cycles.
- Arithmetic, SIGNED=0: prod = A*B in 2*WIDTH bits, with no overflow possible.
- Arithmetic, SIGNED=1:
  - Operands are converted to magnitudes in WIDTH bits; the magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits.
  - The unsigned product is negated in 2*WIDTH bits when the operand signs differ.
  - A zero product is always +0.
- err is cleared only by reset. An illegal pattern outside WAIT_DATA also sets err and is otherwise ignored.
- The output is never a partial mix: all 2*WIDTH rail pairs switch on the same clock edge.

Decomposition:
- Package ncl_seq_pkg holds:
  - the FSM state enum (WAIT_DATA, MULT, DRIVE, HOLD, RETURN);
  - functions dr_all_data, dr_all_null and dr_illegal over rail1/rail0 vectors;
  - the function dr_encode(value) returning the {rail1, rail0} pair.
- Sub-module ncl_dr_sync (parameter N): SYNC_STAGES synchroniser on 2N rails plus the 2-cycle stability filter. Outputs are the synchronised rails, stable_data, stable_null and illegal. It is instantiated once, over the concatenation of A and B.

Test Plan:
1. WIDTH=3, SIGNED=0, a=5, b=7, ki=1 -> p_rail1=6'b100011, p_rail0=6'b011100 at E+6. Then ki=0 -> p NULL. Then inputs NULL -> ko=1, busy=0.
2. WIDTH=3, SIGNED=0, a=7, b=7 -> p_rail1=6'b110001. Then a=0, b=6 -> p_rail1=0, p_rail0=6'b111111.
3. WIDTH=4, SIGNED=1, a=4'b1000 (-8), b=3 -> p_rail1=8'b11101000 (-24). Then a=-8, b=-8 -> p_rail1=8'b01000000 (64).
4. Bit0 of A driven with both rails high -> err=1, ko stays 1, no capture. Legal data follows -> product correct, err stays 1.
5. ki held 0 through MULT -> p stays NULL in DRIVE. Raise ki -> DATA appears SYNC_STAGES+1 cycles later. Assert rst_n=0 in HOLD -> p NULL, ko=1 without waiting for a clock.
6. A changes from 3 to 6 one cycle into the stability window (b=2) -> only the stable value is captured, p=12. A partial DATA pattern held for 10 cycles -> no capture.
